// File: rtl/checksum_accum.sv
// ============================================================================
// checksum_accum : streaming 16-bit ones'-complement checksum (RFC 1071 style).
// Optional macro CSUM_VERIFY_EN adds out_ok (sum == 16'hFFFF at packet end).
// Revision: 1.0
// ============================================================================
`default_nettype none

module checksum_accum #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_csum,
  output logic [LEN_W-1:0] out_len
`ifdef CSUM_VERIFY_EN
  ,
  output logic             out_ok
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [15:0]      r_sum;
  logic [7:0]       r_hi;
  logic             r_phase;
  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_csum;

  logic             w_acc;
  logic             w_out_hs;
  logic             w_do_add;
  logic [15:0]      w_word;
  logic [15:0]      w_sum_nxt;

  // End-around carry: the folded result cannot carry out a second time.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  assign w_acc     = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  assign w_word    = r_phase ? {r_hi, in_data} : {in_data, 8'h00};
  assign w_do_add  = w_acc && (r_phase || in_last);
  assign w_sum_nxt = w_do_add ? oc_add(r_sum, w_word) : r_sum;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_state_nxt = in_last ? S_DONE : S_ACCUM;
      S_ACCUM: if (w_acc && in_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: in_ready  = 1'b1;
      S_DONE:          out_valid = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sum   <= 16'h0000;
      r_hi    <= 8'h00;
      r_phase <= 1'b0;
      r_len   <= '0;
      r_csum  <= 16'hFFFF;
    end else if (w_out_hs) begin
      r_sum   <= 16'h0000;
      r_phase <= 1'b0;
      r_len   <= '0;
      r_csum  <= 16'hFFFF;
    end else if (w_acc) begin
      if (!r_phase) r_hi <= in_data;
      r_phase <= in_last ? 1'b0 : ~r_phase;
      r_sum   <= w_sum_nxt;
      r_csum  <= ~w_sum_nxt;
      if (!(&r_len)) r_len <= r_len + 1'b1;
    end
  end

  assign out_csum = r_csum;
  assign out_len  = r_len;

`ifdef CSUM_VERIFY_EN
  logic r_ok;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                  r_ok <= 1'b0;
    else if (w_out_hs)           r_ok <= 1'b0;
    else if (w_acc && in_last)   r_ok <= (w_sum_nxt == 16'hFFFF);
  end

  assign out_ok = r_ok;
`endif

endmodule

`default_nettype wire

// File: tb/tb_checksum_accum.sv
// ============================================================================
// tb_checksum_accum : table vectors, corner sequences and random packets
// checked against an arithmetic checksum model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_checksum_accum;

  localparam int LEN_W = 4;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             clk;
  logic             rst_l;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_csum;
  logic [LEN_W-1:0] out_len;
`ifdef CSUM_VERIFY_EN
  logic             out_ok;
`endif

  checksum_accum #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_csum  (out_csum),
    .out_len   (out_len)
`ifdef CSUM_VERIFY_EN
    ,
    .out_ok    (out_ok)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] pkt[$];

  typedef struct {
    string       name;
    int          n;
    logic [79:0] d;
    int          gap;
    int          hold;
    logic [15:0] csum;
    int          len;
    logic        ok;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: sum all big-endian words as a wide integer, fold carries at the end.
  function automatic logic [15:0] model_csum();
    longint s = 0;
    for (int i = 0; i < pkt.size(); i += 2) begin
      s += (longint'(pkt[i]) << 8) | ((i + 1 < pkt.size()) ? longint'(pkt[i+1]) : 0);
    end
    while ((s >> 16) != 0) s = (s & 16'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_csum"}, {16'd0, out_csum}, 32'h0000FFFF);
    chk({nm, "_len"}, {{(32-LEN_W){1'b0}}, out_len}, 32'd0);
`ifdef CSUM_VERIFY_EN
    chk({nm, "_ok"}, {31'd0, out_ok}, 32'd0);
`endif
  endtask

  task automatic run_pkt(input string nm, input int gap, input int hold,
                         input logic [15:0] exp_csum, input int exp_len, input logic exp_ok);
    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(pkt[i], (i == pkt.size() - 1));
      if (i != pkt.size() - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    chk({nm, "_latency"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_csum"}, {16'd0, out_csum}, {16'd0, exp_csum});
    chk({nm, "_len"}, {{(32-LEN_W){1'b0}}, out_len}, exp_len);
`ifdef CSUM_VERIFY_EN
    chk({nm, "_ok"}, {31'd0, out_ok}, {31'd0, exp_ok});
`else
    if (exp_ok === 1'bx) $display("note: unexpected X in expected ok");
`endif
    // Upstream keeps offering a byte while the result is held; it must be ignored.
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_data   = 8'h55;
      in_last   = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({nm, "_hold_csum"}, {16'd0, out_csum}, {16'd0, exp_csum});
      chk({nm, "_hold_len"}, {{(32-LEN_W){1'b0}}, out_len}, exp_len);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_reset_vals({nm, "_post"});
  endtask

  task automatic load_vec(input vec_t v);
    pkt.delete();
    for (int k = 0; k < v.n; k++) pkt.push_back(v.d[8*(v.n-1-k) +: 8]);
  endtask

  initial begin
    rst_l     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{"rfc1071",   8, 80'h0001F203F4F5F6F7,     0, 0, 16'h220D, 8,  1'b0};
    vecs[1] = '{"odd3",      3, 80'h010203,               0, 0, 16'hFBFD, 3,  1'b0};
    vecs[2] = '{"single",    1, 80'hAB,                   0, 0, 16'h54FF, 1,  1'b0};
    vecs[3] = '{"carry",     4, 80'hFFFFFFFF,             0, 0, 16'h0000, 4,  1'b1};
    vecs[4] = '{"zero",      2, 80'h0000,                 0, 0, 16'hFFFF, 2,  1'b0};
    vecs[5] = '{"gapped",    8, 80'h0001F203F4F5F6F7,     2, 3, 16'h220D, 8,  1'b0};
    vecs[6] = '{"verify_ok", 10, 80'h0001F203F4F5F6F7220D, 1, 0, 16'h0000, 10, 1'b1};
    vecs[7] = '{"verify_bad",10, 80'h0001F203F4F5F6F7220E, 0, 1, 16'hFFFE, 10, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_l = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      load_vec(vecs[v]);
      run_pkt(vecs[v].name, vecs[v].gap, vecs[v].hold, vecs[v].csum, vecs[v].len, vecs[v].ok);
    end

    // Asynchronous reset mid-packet discards the partial sum.
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    #2 rst_l = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(posedge clk); #1;
    pkt = '{8'h01, 8'h02, 8'h03};
    run_pkt("after_reset", 0, 0, 16'hFBFD, 3, 1'b0);

    // Random packets, including lengths beyond the saturating counter.
    for (int r = 0; r < 40; r++) begin
      int n;
      logic [15:0] exp_c;
      n = $urandom_range(20, 1);
      pkt.delete();
      for (int k = 0; k < n; k++)
        pkt.push_back(($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom));
      exp_c = model_csum();
      run_pkt($sformatf("rand%0d", r), $urandom_range(2, 0), $urandom_range(3, 0),
              exp_c, (n > LEN_MAX) ? LEN_MAX : n, (exp_c == 16'h0000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
